mul_sequencer: RTL and testbench

Iterative shift-and-add multiplier controller that borrows the shared 32-bit ALU to compute the low 32 bits of a 32×32 product (RV32M `MUL` semantics). It sits beside the multicycle control unit. While `busy` is high, the datapath's ALU input mux selects this block's `alu_in1`, `alu_in2` and `alu_sl` instead of the normal control-unit sources. The block handles operand capture, iteration sequencing, early termination and the result handshake.

---
 rtl/alu_pkg.sv | 17 +
 rtl/mul_sequencer_if.sv | 27 ++
 rtl/mul_datapath_regs.sv | 73 +++++++
 rtl/mul_sequencer.sv | 91 +++++++++
 tb/tb_mul_sequencer.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU operation codes and the multiplier sequencer state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_sequencer_if.sv
// Request/result handshake plus the borrowed-ALU operand and return path.
interface mul_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] alu_in1;
    logic [WIDTH-1:0] alu_in2;
    logic [2:0]       alu_sl;
    logic [WIDTH-1:0] alu_out;

    // Requester and ALU side
    modport master (
        output start, a, b, alu_out,
        input  busy, done, result, alu_in1, alu_in2, alu_sl
    );

    // Multiplier sequencer side
    modport slave (
        input  start, a, b, alu_out,
        output busy, done, result, alu_in1, alu_in2, alu_sl
    );
endinterface

// File: rtl/mul_datapath_regs.sv
// Shift-and-add operand registers: accumulator, multiplicand, multiplier, counter.
module mul_datapath_regs #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] alu_out_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] mcand_o,
    output logic [WIDTH-1:0] acc_next_c_o,
    output logic             last_c_o
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Accumulator value after this iteration, and whether this is the final one
    assign acc_next_c_o = mplier_q[0] ? alu_out_i : acc_q;
    assign last_c_o     = (mplier_q[WIDTH-1:1] == '0) || (cnt_q == CNT_W'(WIDTH - 1));

    assign acc_o   = acc_q;
    assign mcand_o = mcand_q;

    // Load on accept, shift per RUN cycle; clear after the last step so the
    // ALU operand outputs read zero whenever the sequencer is not iterating
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            acc_d    = '0;
            mcand_d  = a_i;
            mplier_d = b_i;
            cnt_d    = '0;
        end else if (step_i) begin
            if (last_c_o) begin
                acc_d    = '0;
                mcand_d  = '0;
                mplier_d = '0;
                cnt_d    = '0;
            end else begin
                acc_d    = acc_next_c_o;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
            end
        end
    end

    // Register update with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// Iterative shift-and-add MUL controller driving the shared ALU while busy.
module mul_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    mul_sequencer_if.slave bus
);

    mul_state_t       state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             load_c, step_c;
    logic [WIDTH-1:0] acc, mcand, acc_next_c;
    logic             last_c;

    assign load_c = (state_q == IDLE) && bus.start;
    assign step_c = (state_q == RUN);

    mul_datapath_regs #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_regs (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load_c),
        .step_i       (step_c),
        .a_i          (bus.a),
        .b_i          (bus.b),
        .alu_out_i    (bus.alu_out),
        .acc_o        (acc),
        .mcand_o      (mcand),
        .acc_next_c_o (acc_next_c),
        .last_c_o     (last_c)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state; result captured on DONE entry
    always_comb begin
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
        result_d = result_q;
        if (step_c && last_c) begin
            result_d = acc_next_c;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.alu_in1 = acc;
    assign bus.alu_in2 = mcand;
    assign bus.alu_sl  = ALU_ADD;

endmodule

// File: tb/tb_mul_sequencer.sv
// Randomized and directed checks of mul_sequencer against an a*b reference.
module tb_mul_sequencer;
    import alu_pkg::*;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    mul_sequencer_if #(.WIDTH(32)) bus ();

    mul_sequencer #(
        .WIDTH (32),
        .CNT_W (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural shared ALU
    always_comb begin
        case (bus.alu_sl)
            ALU_ADD: bus.alu_out = bus.alu_in1 + bus.alu_in2;
            ALU_SUB: bus.alu_out = bus.alu_in1 - bus.alu_in2;
            ALU_AND: bus.alu_out = bus.alu_in1 & bus.alu_in2;
            ALU_OR:  bus.alu_out = bus.alu_in1 | bus.alu_in2;
            ALU_XOR: bus.alu_out = bus.alu_in1 ^ bus.alu_in2;
            ALU_SLT: bus.alu_out = 32'($signed(bus.alu_in1) < $signed(bus.alu_in2));
            default: bus.alu_out = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Iterations needed: one per multiplier bit up to the highest set bit, minimum one
    function automatic int ref_iters(input logic [31:0] b);
        int n;
        n = 1;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) n = i + 1;
        end
        return n;
    endfunction

    // One multiply; called #1 after a clock edge with the DUT in IDLE.
    // mid > 0 pulses start with other operands in that RUN cycle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int mid);
        logic [31:0] prod;
        int          n;
        int          lat;
        bit          got;
        bit          busy_ok;
        bit          sl_ok;
        prod    = a * b;
        n       = ref_iters(b);
        lat     = 0;
        got     = 0;
        busy_ok = 1;
        sl_ok   = 1;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            if (bus.done) begin
                got = 1;
                lat = c;
            end else begin
                if (!bus.busy) busy_ok = 0;
                if (bus.alu_sl != ALU_ADD) sl_ok = 0;
                if (c == mid) begin
                    bus.start = 1'b1;
                    bus.a     = 32'h0000_0009;
                    bus.b     = 32'h0000_0009;
                end else begin
                    bus.start = 1'b0;
                end
                @(posedge clk);
                #1;
            end
        end
        bus.start = 1'b0;
        check("done_latency", 32'(lat), 32'(n + 1));
        check("busy_run", 32'(busy_ok), 32'd1);
        check("alu_sl_run", 32'(sl_ok), 32'd1);
        if (got) begin
            check("result", bus.result, prod);
            check("busy_done", 32'(bus.busy), 32'd1);
            check("alu_in1_done", bus.alu_in1, 32'd0);
            @(posedge clk);
            #1;
            check("busy_idle", 32'(bus.busy), 32'd0);
            check("done_idle", 32'(bus.done), 32'd0);
            check("result_hold", bus.result, prod);
            check("alu_in2_idle", bus.alu_in2, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #12;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_alu_in1", bus.alu_in1, 32'd0);
        check("rst_alu_in2", bus.alu_in2, 32'd0);
        check("rst_alu_sl", 32'(bus.alu_sl), 32'd0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(32'd3, 32'd5, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(32'h1234_5678, 32'h0000_0000, 0);
        run_op(32'd7, 32'd6, 0);
        run_op(32'd100, 32'd200, 3);

        // Asynchronous reset in the 10th RUN cycle
        bus.start = 1'b1;
        bus.a     = 32'd2;
        bus.b     = 32'h8000_0000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        check("pre_abort_busy", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_result", bus.result, 32'd0);
        check("abort_alu_in1", bus.alu_in1, 32'd0);
        check("abort_alu_in2", bus.alu_in2, 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) begin
                check("abort_no_done", {30'd0, bus.busy, bus.done}, 32'd0);
            end
        end
        check("abort_quiet", {30'd0, bus.busy, bus.done}, 32'd0);
        run_op(32'd2, 32'h8000_0000, 0);

        // Randomized stress
        for (int k = 0; k < 1000; k++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 15) == 0) rb = '0;
            run_op(ra, rb, ($urandom_range(0, 7) == 0) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
